// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: mul/div freeze, load-use bubble,
// taken-branch squash and HALT drain. Define STALL_PERF_EN to build the stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idex_memRead,
  input  logic [3:0]        idex_regDes,
  input  logic              idex_mdOp,
  input  logic              ex_branchTaken,
  input  logic              ex_halt,
  input  logic [3:0]        ifid_rs1,
  input  logic [3:0]        ifid_rs2,
  input  logic              ifid_rs1_used,
  input  logic              ifid_rs2_used,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              memwb_en,
  output logic              md_busy,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             load_use;

  assign load_use = idex_memRead &
                    ((ifid_rs1_used & (ifid_rs1 == idex_regDes)) |
                     (ifid_rs2_used & (ifid_rs2 == idex_regDes)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    md_busy     = 1'b0;
    halted      = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_halt) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          state_d     = HALT;
        end else if (idex_mdOp && (MD_CYCLES > 1)) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          md_cnt_d    = CNT_W'(MD_CYCLES - 1);
          state_d     = MD_BUSY;
        end else if (ex_branchTaken) begin
          // Squashing the ID instruction makes any load-use hazard on it moot.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      MD_BUSY: begin
        md_busy  = 1'b1;
        md_cnt_d = md_cnt_q - 1'b1;
        if (md_cnt_q > CNT_W'(1)) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
        halted      = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      md_busy     = 1'b0;
      halted      = 1'b0;
    end
  end

`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_en && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
